mips_muldiv_seq: RTL
====================

Name: mips_muldiv_seq

Overview:
- Iterative multiply/divide sequencer for MULT, MULTU, DIV and DIVU. Owns the architectural HI/LO registers.
- Sits beside the execute-stage ALU. Decode issues one request; the block runs a fixed-latency shift-add (multiply) or restoring (divide) loop.
- Results are read via hi/lo for MFHI/MFLO. MTHI/MTLO write them directly.

Parameters:
XLEN, 32, operand width; iteration count equals XLEN (only 32 verified)

Ports:
clk  in  1  system clock, rising edge
rst_b  in  1  reset, asynchronous, active-low
req_valid  in  1  operation request
req_ready  out  1  block can accept (state IDLE)
req_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
req_a  in  XLEN  rs operand (multiplicand / dividend)
req_b  in  XLEN  rt operand (multiplier / divisor)
kill  in  1  abort in-flight op (pipeline flush)
wr_hi  in  1  MTHI write strobe
wr_lo  in  1  MTLO write strobe
wr_data  in  XLEN  MTHI/MTLO data
busy  out  1  operation in flight (not IDLE)
done  out  1  one-cycle pulse: HI/LO hold new result
div_zero  out  1  valid with done: DIV/DIVU with req_b==0
hi  out  XLEN  HI register
lo  out  XLEN  LO register

Behaviour:
- One clock domain; reset asynchronous, active-low on rst_b.
- Reset: state IDLE; hi=0, lo=0, done=0, div_zero=0, busy=0, req_ready=1. Internal accumulators are cleared.
- Reset mid-operation discards the operation with no done.
- States: IDLE -> PREP -> RUN -> FIXUP -> IDLE.
- Accept: req_valid && req_ready && !kill at a clock edge (call it cycle 0).
  - Operands and op are latched; later changes of req_a/req_b are ignored.
  - Next state is PREP.
- PREP (1 cycle):
  - For signed ops, take magnitudes |a| and |b|; -2^31 maps to 0x80000000 unsigned.
  - Record neg_prod = a[31]^b[31], neg_quo = a[31]^b[31], neg_rem = a[31].
  - Unsigned ops clear all three sign flags.
- RUN (XLEN cycles, counter 0..XLEN-1, one iteration per cycle):
  - Multiply: 64-bit {acc,mplr}; if mplr[0], add the multiplicand into the upper half with carry-out; then shift right 1.
  - Divide: {rem,quo} shift left 1; trial = rem - divisor (XLEN+1 bits); if non-negative, rem = trial and set quo[0].
- FIXUP (1 cycle): HI/LO are written at the FIXUP exit edge.
  - Multiply: 64-bit two's-complement negate if neg_prod; hi=upper, lo=lower.
  - Divide: lo = neg_quo ? -quo : quo; hi = neg_rem ? -rem : rem. Results wrap to XLEN bits.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero (b==0, either signedness): hi = original req_a, lo = all ones, div_zero=1. Latency is unchanged.
- done and div_zero:
  - done pulses high for exactly 1 cycle, in cycle XLEN+3 (35), which is the IDLE cycle after FIXUP.
  - req_ready is also 1 in that cycle, so back-to-back accept is allowed.
  - div_zero is valid only while done=1 and is 0 otherwise.
- kill:
  - In PREP, RUN or FIXUP: next state is IDLE; hi/lo unchanged; no done.
  - kill is sampled in FIXUP before the HI/LO write (kill wins).
  - In IDLE, kill blocks acceptance.
- MTHI/MTLO:
  - wr_hi/wr_lo take effect at the edge only when state==IDLE, with hi/lo visible the next cycle.
  - Both strobes may be asserted together.
  - Writes while busy are dropped silently.
  - An accept and a write in the same cycle: the write lands; the later result overwrites it.
- busy = (state != IDLE); req_ready = (state == IDLE). Both are combinational from state.
- hi/lo are stable (unchanged) throughout PREP/RUN.

Test Plan:
1. MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done only in cycle 35; hi=0xFFFFFFFE lo=0x00000001; busy=1 in cycles 1-34; hi/lo unchanged before done.
2. MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1. MULT 0x80000000*0x80000000 -> hi=0x40000000 lo=0.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=0x1234 b=0 -> done with div_zero=1, hi=0x1234, lo=0xFFFFFFFF. The next op has div_zero=0.
5. kill asserted in cycle 10 of a MULTU -> no done; hi/lo keep prior values; req_ready=1 in cycle 11. rst_b low in cycle 20 of a DIV -> hi=lo=0 immediately, no done.
6. wr_hi=1 data=0xAAAA while busy -> hi unchanged. wr_lo=1 data=0x55 in IDLE -> lo=0x55 next cycle. Accept an op in the done cycle of the previous op -> second done exactly 35 cycles later.

Source files
------------

// File: rtl/mips_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Shift-add multiply and restoring divide, XLEN iterations, fixed latency.
module mips_muldiv_seq #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [1:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   input  logic            kill,
   input  logic            wr_hi,
   input  logic            wr_lo,
   input  logic [XLEN-1:0] wr_data,
   output logic            busy,
   output logic            done,
   output logic            div_zero,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

   typedef enum logic [1:0] {IDLE, PREP, RUN, FIXUP} state_e;

   state_e            state;
   logic              is_div;
   logic              is_signed;
   logic              neg_ab;
   logic              neg_rem;
   logic [XLEN-1:0]   a_org;
   logic [XLEN-1:0]   operand;
   logic [XLEN-1:0]   acc;
   logic [XLEN-1:0]   lo_sh;
   logic [CW-1:0]     cnt;

   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     trial;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   res_hi;
   logic [XLEN-1:0]   res_lo;

   assign busy      = (state != IDLE);
   assign req_ready = (state == IDLE);

   // acc/lo_sh/operand are shared: {acc,lo_sh} is the product pair for
   // multiply and the {rem,quo} pair for divide; operand holds mcand/divisor.
   always_comb begin
      a_neg    = is_signed & a_org[XLEN-1];
      b_neg    = is_signed & operand[XLEN-1];
      mag_a    = a_neg ? -a_org : a_org;
      mag_b    = b_neg ? -operand : operand;
      mul_sum  = {1'b0, acc} + (lo_sh[0] ? {1'b0, operand} : '0);
      rem_sh   = {acc, lo_sh[XLEN-1]};
      trial    = rem_sh - {1'b0, operand};
      prod     = {acc, lo_sh};
      prod_fix = neg_ab ? -prod : prod;
      if (!is_div) begin
         res_hi = prod_fix[2*XLEN-1:XLEN];
         res_lo = prod_fix[XLEN-1:0];
      end else if (operand == '0) begin
         res_hi = a_org;
         res_lo = '1;
      end else begin
         res_hi = neg_rem ? -acc : acc;
         res_lo = neg_ab ? -lo_sh : lo_sh;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         is_div    <= 1'b0;
         is_signed <= 1'b0;
         neg_ab    <= 1'b0;
         neg_rem   <= 1'b0;
         a_org     <= '0;
         operand   <= '0;
         acc       <= '0;
         lo_sh     <= '0;
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_hi) hi <= wr_data;
               if (wr_lo) lo <= wr_data;
               if (req_valid && !kill) begin
                  is_div    <= req_op[1];
                  is_signed <= ~req_op[0];
                  a_org     <= req_a;
                  operand   <= req_b;
                  state     <= PREP;
               end
            end
            PREP: begin
               if (kill) begin
                  state <= IDLE;
               end else begin
                  neg_ab  <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
                  acc     <= '0;
                  cnt     <= '0;
                  if (is_div) begin
                     lo_sh   <= mag_a;
                     operand <= mag_b;
                  end else begin
                     lo_sh   <= mag_b;
                     operand <= mag_a;
                  end
                  state <= RUN;
               end
            end
            RUN: begin
               if (kill) begin
                  state <= IDLE;
               end else begin
                  if (is_div) begin
                     if (!trial[XLEN]) begin
                        acc   <= trial[XLEN-1:0];
                        lo_sh <= {lo_sh[XLEN-2:0], 1'b1};
                     end else begin
                        acc   <= rem_sh[XLEN-1:0];
                        lo_sh <= {lo_sh[XLEN-2:0], 1'b0};
                     end
                  end else begin
                     acc   <= mul_sum[XLEN:1];
                     lo_sh <= {mul_sum[0], lo_sh[XLEN-1:1]};
                  end
                  cnt <= cnt + CW'(1);
                  if (cnt == CW'(XLEN - 1)) state <= FIXUP;
               end
            end
            FIXUP: begin
               state <= IDLE;
               if (!kill) begin
                  hi       <= res_hi;
                  lo       <= res_lo;
                  done     <= 1'b1;
                  div_zero <= is_div && (operand == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
